ccff_config_loader: RTL and testbench

- Sequences programming of the FPGA fabric's configuration chain (ccff) from a byte-wide host stream.
- Generates prog_clk, ccff_head and set, and holds the fabric's user reset until programming completes.
- Sits between the TinyTapeout I/O mux and the fabric wrapper's ccff_head_fm, prog_clk_fm and set_fm inputs.
- Removes the need for the host to bit-bang the chain.

---
 rtl/ccff_config_loader.sv | 167 ++++++++++++++++
 tb/tb_ccff_config_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_config_loader.sv
// Streams host configuration bytes MSB-first into the fabric ccff chain, generating prog_clk/set.
// Define CCFF_CRC_EN to append a CRC-16-CCITT trailer check (two extra bytes) after the chain bits.
module ccff_config_loader #(
    parameter int CHAIN_LEN  = 1024,
    parameter int PROG_DIV   = 2,
    parameter int SET_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       ccff_head,
    input  logic       ccff_tail,
    output logic       prog_clk,
    output logic       set,
    output logic       fabric_reset,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int DW = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;
    localparam int SW = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_CRC, S_DONE, S_ERROR} state_t;
    state_t state, state_next;

    logic [SW-1:0] set_cnt;
    logic [DW-1:0] div_cnt;
    logic [CW-1:0] bit_cnt;
    logic [6:0]    shreg;
    logic [2:0]    bit_idx;
    logic          buf_full, prog_clk_r, head_r;
    logic          accept, phase_end, rise, bit_end, last_bit, unused_ok;

    assign accept    = (state == S_SHIFT) && !buf_full && cfg_valid;
    assign phase_end = (state == S_SHIFT) && buf_full && (div_cnt == DW'(PROG_DIV - 1));
    assign rise      = phase_end && !prog_clk_r;
    assign bit_end   = phase_end && prog_clk_r;
    // bit_cnt already includes the rising edge of the bit whose high phase is ending
    assign last_bit  = bit_end && (bit_cnt == CW'(CHAIN_LEN));

`ifdef CCFF_CRC_EN
    logic [15:0] crc, crc_step;
    logic [7:0]  crc_hi;
    logic        crc_hold, crc_second, crc_accept, crc_match, tail_dbg;

    assign crc_accept = (state == S_CRC) && !crc_hold && cfg_valid;
    assign crc_match  = ({crc_hi, cfg_data} == crc);
    assign crc_step   = {crc[14:0], 1'b0} ^ ((crc[15] ^ head_r) ? 16'h1021 : 16'h0000);
    assign unused_ok  = &{1'b0, tail_dbg};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc        <= 16'hFFFF;
            crc_hi     <= '0;
            crc_hold   <= 1'b0;
            crc_second <= 1'b0;
            tail_dbg   <= 1'b0;
        end else begin
            crc_hold <= crc_accept;
            if (state == S_CLEAR) begin
                crc        <= 16'hFFFF;
                crc_second <= 1'b0;
            end
            if (rise) begin
                crc      <= crc_step;
                tail_dbg <= ccff_tail;
            end
            if (crc_accept) begin
                crc_hi     <= cfg_data;
                crc_second <= 1'b1;
            end
        end
    end
`else
    assign unused_ok = &{1'b0, ccff_tail};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_CLEAR;
            S_CLEAR: if (set_cnt == SW'(SET_CYCLES - 1)) state_next = S_SHIFT;
`ifdef CCFF_CRC_EN
            S_SHIFT: if (last_bit) state_next = S_CRC;
            S_CRC:   if (crc_accept && crc_second) state_next = crc_match ? S_DONE : S_ERROR;
`else
            S_SHIFT: if (last_bit) state_next = S_DONE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready    = 1'b0;
        ccff_head    = 1'b0;
        error        = 1'b0;
        set          = (state == S_CLEAR);
        busy         = (state == S_CLEAR) || (state == S_SHIFT) || (state == S_CRC);
        done         = (state == S_DONE);
        fabric_reset = (state != S_DONE);
        prog_clk     = prog_clk_r;
        if (state == S_SHIFT) begin
            cfg_ready = !buf_full;
            ccff_head = head_r;
        end
`ifdef CCFF_CRC_EN
        if (state == S_CRC) cfg_ready = !crc_hold;
        error = (state == S_ERROR);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            set_cnt    <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            buf_full   <= 1'b0;
            prog_clk_r <= 1'b0;
            head_r     <= 1'b0;
        end else begin
            set_cnt <= (state == S_CLEAR) ? set_cnt + SW'(1) : '0;
            if (state == S_CLEAR) begin
                div_cnt    <= '0;
                bit_cnt    <= '0;
                buf_full   <= 1'b0;
                prog_clk_r <= 1'b0;
                head_r     <= 1'b0;
            end
            // The MSB goes straight to ccff_head so the low phase starts the cycle after accept
            if (accept) begin
                shreg    <= cfg_data[6:0];
                head_r   <= cfg_data[7];
                bit_idx  <= '0;
                div_cnt  <= '0;
                buf_full <= 1'b1;
            end
            if ((state == S_SHIFT) && buf_full) begin
                div_cnt <= phase_end ? '0 : div_cnt + DW'(1);
                if (rise) begin
                    prog_clk_r <= 1'b1;
                    bit_cnt    <= bit_cnt + CW'(1);
                end
                if (bit_end) begin
                    prog_clk_r <= 1'b0;
                    if (last_bit || (bit_idx == 3'd7)) begin
                        buf_full <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        head_r  <= shreg[6];
                        shreg   <= {shreg[5:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ccff_config_loader.sv
// Directed bench for ccff_config_loader: scoreboard of expected chain bits checked at each prog_clk rise.
// Define CCFF_CRC_EN to exercise the CRC trailer build instead of the plain shift runs.
module tb_ccff_config_loader;
`ifdef CCFF_CRC_EN
    localparam int CHAIN = 16;
`else
    localparam int CHAIN = 12;
`endif
    localparam int PDIV = 1;
    localparam int SETC = 4;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, cfg_valid = 1'b0, ccff_tail = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready, ccff_head, prog_clk, set, fabric_reset, busy, done, error;

    logic       start_s = 1'b0, cfg_valid_s = 1'b0;
    logic [7:0] cfg_data_s = 8'h00;
    logic       cfg_ready_s, ccff_head_s, prog_clk_s, set_s, fabric_reset_s, busy_s, done_s, error_s;

    int   checks = 0, errors = 0, cyc = 0, rises = 0, hs = 0, pushed = 0;
    int   set_len = 0, hi_len = 0;
    logic prev_pclk = 1'b0, prev_head = 1'b0, prev_set = 1'b0;
    logic exp_q[$];

    ccff_config_loader #(.CHAIN_LEN(CHAIN), .PROG_DIV(PDIV), .SET_CYCLES(SETC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk(prog_clk),
        .set(set), .fabric_reset(fabric_reset), .busy(busy), .done(done), .error(error)
    );

    ccff_config_loader #(.CHAIN_LEN(12), .PROG_DIV(3), .SET_CYCLES(SETC)) dut_slow (
        .clk(clk), .rst_n(rst_n), .start(start_s), .cfg_data(cfg_data_s), .cfg_valid(cfg_valid_s),
        .cfg_ready(cfg_ready_s), .ccff_head(ccff_head_s), .ccff_tail(ccff_tail), .prog_clk(prog_clk_s),
        .set(set_s), .fabric_reset(fabric_reset_s), .busy(busy_s), .done(done_s), .error(error_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Outputs sampled on the falling edge; inputs change 1 time unit after the rising edge.
    always @(negedge clk) begin
        if (cfg_valid && cfg_ready) hs++;
        if (prog_clk && !prev_pclk) begin
            rises++;
            check("rise_within_chain", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("head_bit", ccff_head, exp_q.pop_front());
        end
        if (prog_clk && prev_pclk) check("head_stable_high", ccff_head, prev_head);
        if (set) set_len++;
        else if (prev_set) begin
            check("set_len", set_len, SETC);
            set_len = 0;
        end
        if (prog_clk) hi_len++;
        else if (prev_pclk) begin
            check("high_len", hi_len, PDIV);
            hi_len = 0;
        end
        prev_pclk = prog_clk;
        prev_head = ccff_head;
        prev_set  = set;
    end

    task automatic kick(output int t0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        pushed = 0;
        rises = 0;
        hs = 0;
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit to_chain);
        int n = 0;
        if (to_chain) begin
            for (int i = 7; i >= 0; i--) begin
                if (pushed < CHAIN) begin
                    exp_q.push_back(b[i]);
                    pushed++;
                end
            end
        end
        cfg_data = b;
        cfg_valid = 1'b1;
        @(negedge clk);
        while (!cfg_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("handshake_in_time", cfg_ready, 1'b1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int t0, output int lat);
        int n = 0;
        while (!(done || error) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_finished"}, done || error, 1'b1);
        lat = cyc - t0;
    endtask

`ifdef CCFF_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [7:0] d0, input logic [7:0] d1);
        logic [15:0] c = 16'hFFFF;
        logic [7:0]  d[2];
        d[0] = d0;
        d[1] = d1;
        for (int k = 0; k < 2; k++) begin
            c ^= {d[k], 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction
`endif

    initial begin
        int   t0, lat, n;
`ifdef CCFF_CRC_EN
        logic [15:0] c;
`else
        logic [15:0] sw;
        int   idx, r, lo, hi;
        logic pp, ph, take;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {cfg_ready, ccff_head, prog_clk, set, busy, done, error, fabric_reset}, 8'b0000_0001);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_outputs", {cfg_ready, ccff_head, prog_clk, set, busy, done, error, fabric_reset}, 8'b0000_0001);
        check("slow_idle_outputs", {cfg_ready_s, ccff_head_s, prog_clk_s, set_s, busy_s, done_s, error_s,
                                    fabric_reset_s}, 8'b0000_0001);
`ifndef CCFF_CRC_EN
        // Run A: always-valid host, with a stray start while shifting
        kick(t0);
        check("start_to_set", {set, busy, fabric_reset}, 3'b111);
        send_byte(8'hA5, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_shift_ignored", {set, busy}, 2'b01);
        send_byte(8'h3F, 1'b1);
        wait_end("run_a", t0, lat);
        check("run_a_latency", lat, SETC + (1 + 8 * 2 * PDIV) + (1 + 4 * 2 * PDIV));
        check("run_a_rises", rises, CHAIN);
        check("run_a_handshakes", hs, 2);
        check("run_a_queue_drained", exp_q.size(), 0);
        check("run_a_done_outputs", {done, fabric_reset, busy, cfg_ready, ccff_head, prog_clk, error}, 7'b1000000);

        // Run B: restart from DONE, host withholds the second byte for 10 cycles
        kick(t0);
        check("restart_from_done", {done, fabric_reset, set, busy}, 4'b0111);
        send_byte(8'hA5, 1'b1);
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_buffer_empty", cfg_ready, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("stall_prog_clk_low", prog_clk, 1'b0);
            check("stall_head_holds", ccff_head, 1'b1);
        end
        send_byte(8'h3F, 1'b1);
        wait_end("run_b", t0, lat);
        check("run_b_latency", lat, SETC + (1 + 8 * 2 * PDIV) + (1 + 4 * 2 * PDIV) + 10);
        check("run_b_rises", rises, CHAIN);
        check("run_b_handshakes", hs, 2);

        // Run C: reset after the 5th prog_clk rise, then a full sequence
        kick(t0);
        send_byte(8'hA5, 1'b1);
        n = 0;
        while (rises < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("rises_before_reset", rises, 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrun_reset_outputs", {cfg_ready, ccff_head, prog_clk, set, busy, done, error, fabric_reset},
              8'b0000_0001);
        @(posedge clk); #1;
        kick(t0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3F, 1'b1);
        wait_end("run_c", t0, lat);
        check("run_c_latency", lat, SETC + (1 + 8 * 2 * PDIV) + (1 + 4 * 2 * PDIV));
        check("run_c_rises", rises, CHAIN);
        check("run_c_done", {done, fabric_reset}, 2'b10);

        // Slow instance: 3-cycle prog_clk phases, always-valid host
        sw = 16'hA53F;
        idx = 0; r = 0; lo = 0; hi = 0; pp = 1'b0; ph = 1'b0;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 400 && !done_s; k++) begin
            cfg_valid_s = (idx < 2);
            cfg_data_s  = (idx == 0) ? 8'hA5 : 8'h3F;
            @(negedge clk);
            take = cfg_valid_s && cfg_ready_s;
            if (prog_clk_s) begin
                if (!pp) begin
                    if (r < 12) check("slow_head_bit", ccff_head_s, sw[15 - r]);
                    if (r % 8 != 0) check("slow_low_len", lo, 3);
                    r++;
                    lo = 0;
                end else begin
                    check("slow_head_stable", ccff_head_s, ph);
                end
                hi++;
            end else begin
                if (pp) begin
                    check("slow_high_len", hi, 3);
                    hi = 0;
                end
                lo++;
            end
            pp = prog_clk_s;
            ph = ccff_head_s;
            @(posedge clk); #1;
            if (take) idx++;
        end
        cfg_valid_s = 1'b0;
        check("slow_done", {done_s, fabric_reset_s, busy_s}, 3'b100);
        check("slow_latency", cyc - t0, SETC + (1 + 8 * 2 * 3) + (1 + 4 * 2 * 3));
        check("slow_rises", r, 12);
`else
        c = crc_ref(8'h12, 8'h34);
        kick(t0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(c[15:8], 1'b0);
        send_byte(c[7:0], 1'b0);
        wait_end("crc_good", t0, lat);
        check("crc_good_status", {done, error, fabric_reset, busy}, 4'b1000);
        check("crc_good_rises", rises, CHAIN);
        check("crc_good_handshakes", hs, 4);
        check("crc_good_queue_drained", exp_q.size(), 0);

        kick(t0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(c[15:8], 1'b0);
        send_byte(c[7:0] ^ 8'h01, 1'b0);
        wait_end("crc_bad", t0, lat);
        check("crc_bad_status", {done, error, fabric_reset, busy}, 4'b0110);
        check("crc_bad_rises", rises, CHAIN);
        check("crc_bad_handshakes", hs, 4);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
